// File: rtl/round_robin_ponderado_param_pkg.sv
// Shared sizing helpers for the weighted round-robin arbiter: field widths,
// modulo increment for any queue count and per-queue weight extraction.
package round_robin_ponderado_param_pkg;

    localparam int PESOS_MAX_W = 1024;

    function automatic int calc_ww(input int max_weight);
        return (max_weight > 1) ? $clog2(max_weight) : 1;
    endfunction

    function automatic int calc_sw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Explicit wrap so non-power-of-two queue counts never produce an out-of-range index
    function automatic int mod_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

    function automatic logic [31:0] peso_de(input logic [PESOS_MAX_W-1:0] v,
                                            input int n, input int ww);
        logic [PESOS_MAX_W-1:0] s;
        s = v >> (n * ww);
        return s[31:0] & ((32'd1 << ww) - 32'd1);
    endfunction

endpackage

// File: rtl/round_robin_ponderado_param_selector_rotativo.sv
// Rotating-priority first-one finder: first eligible queue scanning from
// `actual` upward, wrapping modulo N.
module selector_rotativo #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  eligible,
    input  logic [SW-1:0] actual,
    output logic [SW-1:0] c,
    output logic          any
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             off;
    int             sum;

    always_comb begin
        dbl = {eligible, eligible} >> actual;
        rot = dbl[N-1:0];
        off = 0;
        any = 1'b0;
        // Scan downward so the lowest offset (nearest to the owner) wins
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = k;
                any = 1'b1;
            end
        end
        sum = int'(actual) + off;
        if (sum >= N) sum = sum - N;
        c = SW'(sum);
    end

endmodule

// File: rtl/round_robin_ponderado_param.sv
// Work-conserving weighted round-robin arbiter over QUEUE_QUANTITY FIFOs;
// holds turn credit across cycles and advances only on pop_ready.
module round_robin_ponderado_param
    import round_robin_ponderado_param_pkg::*;
#(
    parameter int QUEUE_QUANTITY = 4,
    parameter int MAX_WEIGHT     = 64,
    localparam int WW = calc_ww(MAX_WEIGHT),
    localparam int SW = calc_sw(QUEUE_QUANTITY)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enb,
    input  logic                         modo,
    input  logic [QUEUE_QUANTITY*WW-1:0] pesos,
    input  logic [QUEUE_QUANTITY-1:0]    buf_empty,
    input  logic                         pop_ready,
    output logic [SW-1:0]                selector,
    output logic                         selector_enb,
    output logic [QUEUE_QUANTITY-1:0]    pop
);

    logic [SW-1:0]             actual_q, actual_d;
    logic [WW-1:0]             credito_q, credito_d;
    logic [WW-1:0]             peso [QUEUE_QUANTITY];
    logic [QUEUE_QUANTITY-1:0] eligible;
    logic [SW-1:0]             c;
    logic                      any;
    logic                      grant;
    logic [WW-1:0]             ew;
    logic [WW-1:0]             rem;

    always_comb begin
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            peso[i]     = WW'(peso_de(PESOS_MAX_W'(pesos), i, WW));
            eligible[i] = !buf_empty[i] && (peso[i] != '0);
        end
    end

    selector_rotativo #(.N(QUEUE_QUANTITY), .SW(SW)) u_sel (
        .eligible (eligible),
        .actual   (actual_q),
        .c        (c),
        .any      (any)
    );

    // Reset also masks the offer so nothing is popped while state is being cleared
    assign selector_enb = enb && !rst && any;
    assign selector     = selector_enb ? c : '0;
    assign grant        = selector_enb && pop_ready;

    always_comb begin
        for (int i = 0; i < QUEUE_QUANTITY; i++)
            pop[i] = grant && (c == SW'(i));
    end

    always_comb begin
        ew        = modo ? WW'(1) : peso[c];
        // Weight is sampled only when a fresh turn starts
        if ((c != actual_q) || (credito_q == '0)) rem = ew - WW'(1);
        else                                      rem = credito_q - WW'(1);
        actual_d  = actual_q;
        credito_d = credito_q;
        if (grant) begin
            if (rem == '0) begin
                actual_d  = SW'(mod_inc(int'(c), QUEUE_QUANTITY));
                credito_d = '0;
            end else begin
                actual_d  = c;
                credito_d = rem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            actual_q  <= '0;
            credito_q <= '0;
        end else begin
            actual_q  <= actual_d;
            credito_q <= credito_d;
        end
    end

endmodule

// File: tb/tb_round_robin_ponderado_param.sv
// Scoreboard bench: expected grants from the test-plan sequences are queued
// as stimulus is driven and compared when the DUT output is sampled.
module tb_round_robin_ponderado_param;

    logic       clk = 1'b0;
    logic       rst, enb, modo, pop_ready;
    logic [23:0] pesos4;
    logic [3:0]  empty4;
    logic [1:0]  sel4;
    logic        en4;
    logic [3:0]  pop4;
    logic [5:0]  pesos3;
    logic [2:0]  empty3;
    logic [1:0]  sel3;
    logic        en3;
    logic [2:0]  pop3;

    int vectors = 0;
    int errs    = 0;
    int cnt [4];

    typedef struct {
        logic       en;
        int         sel;
        logic [3:0] pop;
    } exp_t;

    exp_t exp_q[$];
    int   exp3_q[$];

    always #5 clk = ~clk;

    round_robin_ponderado_param #(.QUEUE_QUANTITY(4), .MAX_WEIGHT(64)) u_dut4 (
        .clk(clk), .rst(rst), .enb(enb), .modo(modo), .pesos(pesos4),
        .buf_empty(empty4), .pop_ready(pop_ready),
        .selector(sel4), .selector_enb(en4), .pop(pop4)
    );

    round_robin_ponderado_param #(.QUEUE_QUANTITY(3), .MAX_WEIGHT(4)) u_dut3 (
        .clk(clk), .rst(rst), .enb(enb), .modo(modo), .pesos(pesos3),
        .buf_empty(empty3), .pop_ready(pop_ready),
        .selector(sel3), .selector_enb(en3), .pop(pop3)
    );

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step4(input logic en, input int sel, input string tag);
        exp_t       e;
        logic [3:0] p;
        for (int i = 0; i < 4; i++) empty4[i] = (cnt[i] == 0);
        e.en  = en;
        e.sel = en ? sel : 0;
        e.pop = (en && pop_ready) ? 4'(1 << sel) : 4'b0;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, ".en"},  int'(en4),  int'(e.en));
        chk({tag, ".sel"}, int'(sel4), e.sel);
        chk({tag, ".pop"}, int'(pop4), int'(e.pop));
        p = pop4;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            if (p[i] && cnt[i] > 0) cnt[i] = cnt[i] - 1;
    endtask

    task automatic step3(input int sel);
        int s;
        exp3_q.push_back(sel);
        @(negedge clk);
        s = exp3_q.pop_front();
        chk("q3.sel",   int'(sel3), s);
        chk("q3.en",    int'(en3), 1);
        chk("q3.pop1",  int'(pop3[1]), 0);
        chk("q3.range", int'(sel3 < 2'd3), 1);
        @(posedge clk);
        #1;
    endtask

    int seq_a [14] = '{0,0,0,1,2,2,3,0,0,0,1,2,2,3};
    int seq_c [26] = '{0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0,0,0,1,1,1,1,2,2,0,0};
    int seq_3 [6]  = '{0,0,2,0,0,2};

    initial begin
        rst = 1'b1; enb = 1'b1; modo = 1'b0; pop_ready = 1'b1;
        pesos4 = {6'd1, 6'd2, 6'd1, 6'd3};
        pesos3 = {2'd1, 2'd0, 2'd2};
        empty3 = 3'b000;
        for (int i = 0; i < 4; i++) cnt[i] = 1000;
        empty4 = 4'b0000;
        @(posedge clk);
        #1;
        step4(1'b0, 0, "rst");
        rst = 1'b0;

        // Weighted 3,1,2,1
        for (int i = 0; i < 14; i++) step4(1'b1, seq_a[i], "wrr");

        // Plain round-robin
        modo = 1'b1;
        for (int i = 0; i < 8; i++) step4(1'b1, i % 4, "rr");
        modo = 1'b0;

        // Stall mid-turn with credit 2 left on queue 1
        pesos4 = {6'd1, 6'd1, 6'd3, 6'd1};
        step4(1'b1, 0, "stall.pre");
        step4(1'b1, 1, "stall.pre");
        pop_ready = 1'b0;
        for (int i = 0; i < 5; i++) step4(1'b1, 1, "stall.hold");
        pop_ready = 1'b1;
        step4(1'b1, 1, "stall.post");
        step4(1'b1, 1, "stall.post");
        step4(1'b1, 2, "stall.next");

        // enb low: no offer, state frozen
        enb = 1'b0;
        step4(1'b0, 0, "enb0");
        enb = 1'b1;
        step4(1'b1, 3, "enb1");

        // Equal weights, queue 0 drains after 2 pops, refilled later; reset mid-turn on 2
        rst = 1'b1;
        step4(1'b0, 0, "rst2");
        rst = 1'b0;
        pesos4 = {6'd4, 6'd4, 6'd4, 6'd4};
        cnt[0] = 2;
        for (int i = 0; i < 24; i++) begin
            if (i == 10) cnt[0] = 1000;
            step4(1'b1, seq_c[i], "drain");
        end
        rst = 1'b1;
        step4(1'b0, 0, "rst_mid");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step4(1'b1, 0, "post_rst");
        step4(1'b1, 1, "post_rst");

        // Three queues, weights 2,0,1
        rst = 1'b1;
        step4(1'b0, 0, "rst3");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step3(seq_3[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/round_robin_ponderado_param.md
# round_robin_ponderado_param

Parametrised, work-conserving weighted round-robin arbiter that selects which of `QUEUE_QUANTITY` FIFOs is popped next toward the shared output. It sits between the per-class FIFO bank and the output serializer. It generalises queue count and weight width, holds the current turn's credit across cycles, skips empty or disabled queues without losing a cycle, and only advances on an explicit consumer handshake. A runtime mode selects weighted or plain round-robin.

## Interface
- `QUEUE_QUANTITY`, 4: number of queues; must be ≥2, any integer (not restricted to a power of two).
- `MAX_WEIGHT`, 64: weight range; weight field width `WW = $clog2(MAX_WEIGHT)`; legal weights 0…2^WW−1.
- `SW` (derived), `$clog2(QUEUE_QUANTITY)`: selector width.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `enb` in 1: arbiter enable; 0 forces no grant and freezes state.
- `modo` in 1: 0 = weighted, 1 = plain round-robin (every non-zero weight treated as 1).
- `pesos` in `QUEUE_QUANTITY*WW`: weight of queue n at bits `[(n+1)*WW-1 : n*WW]`; 0 = queue disabled.
- `buf_empty` in `QUEUE_QUANTITY`: per-FIFO empty flags.
- `pop_ready` in 1: consumer accepts the offered word this cycle.
- `selector` out `SW`: index of the granted queue.
- `selector_enb` out 1: a grant is offered.
- `pop` out `QUEUE_QUANTITY`: one-hot read strobe, `selector_enb & pop_ready` decoded at `selector`.

## Operation
- State: `actual` (SW bits, current turn owner) and `credito` (WW bits, grants remaining in turn; 0 = fresh turn).
- Eligible queue i: `!buf_empty[i] && peso_i != 0`.
- Candidate `c` is the first eligible index scanning `actual, actual+1, …` modulo `QUEUE_QUANTITY`. Wrap is explicit modulo, not bit truncation.
- `selector_enb = enb && any eligible`. `selector = c` when `selector_enb` is 1, else 0.
- A grant occurs when `selector_enb && pop_ready`. On a grant:
  - `ew = modo ? 1 : peso_c`.
  - If `c != actual` or `credito == 0`, then `rem = ew − 1`. Weight is sampled only here, so a weight change mid-turn takes effect next turn.
  - Otherwise `rem = credito − 1`.
  - If `rem == 0`: `actual <= (c+1) mod QUEUE_QUANTITY`, `credito <= 0`.
  - Else: `actual <= c`, `credito <= rem`.
- Owner empties mid-turn: the candidate moves to another queue and the owner's remaining credit is forfeited on that queue's grant.
- Owner's weight set to 0 mid-turn: the queue is ineligible immediately and its credit is forfeited the same way.
- No grant (`pop_ready=0`, `enb=0`, or nothing eligible): state holds and no `pop` is asserted.
- `rst`: `actual=0`, `credito=0`, so `selector=0`, `selector_enb=0`, `pop=0` the cycle after. `rst` has priority over `enb`. Reset mid-turn discards credit.

## Timing
- `selector`, `selector_enb` and `pop` are combinational from registered state, `buf_empty`, `pesos`, `modo`, `enb` and `pop_ready`. Latency is 0 cycles from a flag change to the offer.
- Throughput is one grant per cycle.
- State updates at the posedge ending a grant cycle.
- The FIFO must update `buf_empty` by the next posedge after `pop`. Popping the last word clears eligibility for the following cycle.
- There is no combinational path from `pop_ready` to `selector` or `selector_enb`. `pop_ready` affects only `pop` and the next state.

## Structure
- Shared package holds:
  - `WW` and `SW` derivation functions.
  - The modulo-increment helper for non-power-of-two counts.
  - The weight-field extraction function.
- One combinational sub-module, `selector_rotativo`: rotating-priority first-one finder (inputs `eligible`, `actual`; outputs `c`, `any`).
- The top level holds the credit and owner registers and the `pop` decode.

## Test plan
- Weights 3,1,2,1, all queues full, `pop_ready=1` → `selector` sequence 0,0,0,1,2,2,3, then repeats.
- Same weights with `modo=1` → sequence 0,1,2,3,0…
- Weights 4,4,4,4; queue 0 empties after 2 pops → third grant goes to 1; 1 gets 4 grants, then 2; queue 0 is refilled and served fresh (4 grants) on its next turn.
- `QUEUE_QUANTITY=3`, weight 2,0,1, all full → 0,0,2,0,0,2; queue 1 is never granted; no out-of-range index.
- `pop_ready=0` for 5 cycles mid-turn (credit 2 left on queue 1) → `selector=1` is held, no `pop`; after release exactly 2 more grants go to 1.
- `rst` asserted mid-turn on queue 2 → the next cycle shows `selector_enb=0` and `pop=0`; the first grant after `rst` drops goes to queue 0 with a fresh credit.
